randsack_regrw: RTL and testbench
=================================

RANDSACK_REGRW -- requirements
Module: randsack_regrw

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone window base (256-byte window).
REQ-002 SHALL have parameter ID_VALUE, default 32'h5241_4E44, read-only identification word.
REQ-003 SHALL have port clock  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port resetb  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports wbs_cyc_i / wbs_stb_i / wbs_we_i  input  1 each  Wishbone cycle, strobe, write-enable.
REQ-006 SHALL have port wbs_sel_i  input  4  byte lane selects.
REQ-007 SHALL have ports wbs_adr_i / wbs_dat_i  input  32 each  address, write data.
REQ-008 SHALL have port wbs_ack_o  output  1  transfer acknowledge.
REQ-009 SHALL have port wbs_dat_o  output  32  read data.
REQ-010 SHALL have port checkbits_o  output  16  drives user I/O pads 21..6.
REQ-011 SHALL have port io_oeb_o  output  16  active-low output enables for pads 21..6.

Function
REQ-012 SHALL select the block when wbs_cyc_i & wbs_stb_i and wbs_adr_i[31:8] == BASE_ADDR[31:8]; otherwise SHALL never assert ack.
REQ-013 SHALL register map (offset, byte-addressed): 0x00 ID (RO); 0x04 CHECK (RW, bits 15:0); 0x08 OEB (RW, bits 15:0); 0x0C WCOUNT (RO); 0x10/0x14/0x18/0x1C SCRATCH0-3 (RW, 32-bit).
REQ-014 SHALL assert wbs_ack_o exactly one cycle after a selected request is sampled, for one cycle; the request cycle following an ack SHALL NOT be acked again (ack pulses never back-to-back).
REQ-015 SHALL perform writes in the ack cycle, honouring wbs_sel_i per byte lane; lanes with sel=0 SHALL retain their values.
REQ-016 SHALL return read data on wbs_dat_o in the ack cycle; wbs_dat_o SHALL be 0 in all other cycles.
REQ-017 SHALL read unimplemented bits of CHECK/OEB as 0.
REQ-018 SHALL ack, read 0 and ignore writes at unmapped offsets (0x20-0xFC).
REQ-019 SHALL write to RO registers be acked and ignored.
REQ-020 SHALL drive checkbits_o = CHECK[15:0] and io_oeb_o = OEB[15:0] directly from registers (no extra latency beyond the write edge).
REQ-021 SHALL increment WCOUNT (32-bit, wraps from 0xFFFF_FFFF to 0) on every acked write to CHECK, including writes with wbs_sel_i = 0.

Reset
REQ-022 SHALL, on resetb low, asynchronously clear CHECK = 0x0000, WCOUNT = 0, SCRATCH0-3 = 0, ack = 0, and set OEB = 0xFFFF (pads input).
REQ-023 SHALL abort any in-flight transfer on reset with no ack issued; a request held through reset release SHALL be acked one cycle after the first post-reset sampling edge.

Configuration
REQ-024 SHALL compile SCRATCH0-3 in only when macro RANDSACK_SCRATCH_EN is defined; without it, offsets 0x10-0x1C SHALL behave as unmapped (REQ-018).

Structure
REQ-025 SHALL place register offsets, reset values (OEB 0xFFFF) and the default ID in a shared package randsack_regrw_pkg.
REQ-026 SHALL implement the Wishbone decode/ack logic in one sub-module randsack_wb_slave_if; registers in the top.

Verification
REQ-027 SHALL check reset: after resetb rises, read 0x00 -> 0x5241_4E44, CHECK -> 0, OEB -> 0xFFFF, io_oeb_o = 0xFFFF.
REQ-028 SHALL check GPIO sequence: write OEB=0, CHECK=0x5555, 0xAAAA, 0xFEED -> checkbits_o shows each value in order, WCOUNT reads 3.
REQ-029 SHALL check byte lanes: write SCRATCH0=0xFFFF_FFFF then 0x1234_5678 with sel=4'b0101 -> read 0xFF34_FF78.
REQ-030 SHALL check address decode: write to BASE_ADDR+0x100 -> no ack; write to offset 0x40 -> acked, reads 0.
REQ-031 SHALL check ack protocol: stb held high continuously -> ack pulses every other cycle, one transfer per pulse.
REQ-032 SHALL check async reset mid-transfer: resetb low in the request cycle -> no ack, CHECK returns to 0 immediately.

Source files
------------

// File: rtl/randsack_regrw_pkg.sv
// Shared register map, reset values and decode helpers for the randsack Wishbone register block.
package randsack_regrw_pkg;

  localparam int unsigned DW    = 32;
  localparam int unsigned IOW   = 16;
  localparam int unsigned SELW  = 4;
  localparam int unsigned WORDW = 6;

  localparam logic [DW-1:0] DEF_BASE_ADDR = 32'h3000_0000;
  localparam logic [DW-1:0] DEF_ID_VALUE  = 32'h5241_4E44;

  localparam logic [7:0] OFF_ID       = 8'h00;
  localparam logic [7:0] OFF_CHECK    = 8'h04;
  localparam logic [7:0] OFF_OEB      = 8'h08;
  localparam logic [7:0] OFF_WCOUNT   = 8'h0C;
  localparam logic [7:0] OFF_SCRATCH0 = 8'h10;

  localparam logic [WORDW-1:0] W_ID       = WORDW'(OFF_ID >> 2);
  localparam logic [WORDW-1:0] W_CHECK    = WORDW'(OFF_CHECK >> 2);
  localparam logic [WORDW-1:0] W_OEB      = WORDW'(OFF_OEB >> 2);
  localparam logic [WORDW-1:0] W_WCOUNT   = WORDW'(OFF_WCOUNT >> 2);
  localparam logic [WORDW-1:0] W_SCRATCH0 = WORDW'(OFF_SCRATCH0 >> 2);

  localparam logic [IOW-1:0] CHECK_RST = 16'h0000;
  localparam logic [IOW-1:0] OEB_RST   = 16'hFFFF;

  // Decoded access handed from the bus interface to the register file.
  typedef struct packed {
    logic             rd;
    logic             wr;
    logic [WORDW-1:0] word;
  } wb_cmd_t;

  function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0]   old_v,
                                                 input logic [DW-1:0]   new_v,
                                                 input logic [SELW-1:0] sel);
    logic [DW-1:0] res;
    res = old_v;
    for (int b = 0; b < int'(SELW); b++) begin
      if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/randsack_wb_slave_if.sv
// Wishbone window decode and single-cycle ack generation; acks are never back-to-back.
module randsack_wb_slave_if
  import randsack_regrw_pkg::*;
#(
  parameter logic [DW-1:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic          clock,
  input  logic          resetb,
  input  logic          cyc_i,
  input  logic          stb_i,
  input  logic          we_i,
  input  logic [DW-1:0] adr_i,
  output logic          ack_o,
  output wb_cmd_t       cmd_c
);

  logic ack_q, ack_d;
  logic hit_c;
  logic unused_c;

  assign unused_c = ^adr_i[1:0];

  // A request is sampled only when no ack is currently showing.
  always_comb begin
    hit_c      = cyc_i & stb_i & (adr_i[DW-1:8] == BASE_ADDR[DW-1:8]);
    ack_d      = hit_c & ~ack_q;
    cmd_c      = '0;
    cmd_c.rd   = ack_d & ~we_i;
    cmd_c.wr   = ack_q & hit_c & we_i;
    cmd_c.word = adr_i[7:2];
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) ack_q <= 1'b0;
    else         ack_q <= ack_d;
  end

  assign ack_o = ack_q;

endmodule

// File: rtl/randsack_regrw.sv
// Wishbone register block driving 16 GPIO pads; SCRATCH0-3 exist only with RANDSACK_SCRATCH_EN.
module randsack_regrw
  import randsack_regrw_pkg::*;
#(
  parameter logic [DW-1:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [DW-1:0] ID_VALUE  = DEF_ID_VALUE
) (
  input  logic            clock,
  input  logic            resetb,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [SELW-1:0] wbs_sel_i,
  input  logic [DW-1:0]   wbs_adr_i,
  input  logic [DW-1:0]   wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [DW-1:0]   wbs_dat_o,
  output logic [IOW-1:0]  checkbits_o,
  output logic [IOW-1:0]  io_oeb_o
);

  wb_cmd_t cmd_c;

  logic [IOW-1:0] check_q, check_d;
  logic [IOW-1:0] oeb_q, oeb_d;
  logic [DW-1:0]  wcount_q, wcount_d;
  logic [DW-1:0]  dat_q, dat_d;
  logic [DW-1:0]  rdata_c;
`ifdef RANDSACK_SCRATCH_EN
  logic [DW-1:0]  scratch_q [4];
  logic [DW-1:0]  scratch_d [4];
  logic           scr_hit_c;
`endif

  randsack_wb_slave_if #(
    .BASE_ADDR (BASE_ADDR)
  ) u_wb_if (
    .clock  (clock),
    .resetb (resetb),
    .cyc_i  (wbs_cyc_i),
    .stb_i  (wbs_stb_i),
    .we_i   (wbs_we_i),
    .adr_i  (wbs_adr_i),
    .ack_o  (wbs_ack_o),
    .cmd_c  (cmd_c)
  );

  // Read mux and register next-state; writes land on the edge closing the ack cycle.
  always_comb begin
    check_d  = check_q;
    oeb_d    = oeb_q;
    wcount_d = wcount_q;
    rdata_c  = '0;
`ifdef RANDSACK_SCRATCH_EN
    for (int i = 0; i < 4; i++) scratch_d[i] = scratch_q[i];
    scr_hit_c = (cmd_c.word[WORDW-1:2] == W_SCRATCH0[WORDW-1:2]);
`endif

    case (cmd_c.word)
      W_ID:     rdata_c = ID_VALUE;
      W_CHECK:  rdata_c = {16'h0000, check_q};
      W_OEB:    rdata_c = {16'h0000, oeb_q};
      W_WCOUNT: rdata_c = wcount_q;
      default:  rdata_c = '0;
    endcase
`ifdef RANDSACK_SCRATCH_EN
    if (scr_hit_c) rdata_c = scratch_q[cmd_c.word[1:0]];
`endif

    if (cmd_c.wr) begin
      case (cmd_c.word)
        W_CHECK: begin
          check_d  = IOW'(merge_lanes({16'h0000, check_q}, wbs_dat_i, wbs_sel_i));
          wcount_d = wcount_q + 32'd1;
        end
        W_OEB:   oeb_d = IOW'(merge_lanes({16'h0000, oeb_q}, wbs_dat_i, wbs_sel_i));
        default: ;
      endcase
`ifdef RANDSACK_SCRATCH_EN
      if (scr_hit_c) begin
        scratch_d[cmd_c.word[1:0]] = merge_lanes(scratch_q[cmd_c.word[1:0]], wbs_dat_i, wbs_sel_i);
      end
`endif
    end

    dat_d = cmd_c.rd ? rdata_c : '0;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      check_q  <= CHECK_RST;
      oeb_q    <= OEB_RST;
      wcount_q <= '0;
      dat_q    <= '0;
    end else begin
      check_q  <= check_d;
      oeb_q    <= oeb_d;
      wcount_q <= wcount_d;
      dat_q    <= dat_d;
    end
  end

`ifdef RANDSACK_SCRATCH_EN
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < 4; i++) scratch_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) scratch_q[i] <= scratch_d[i];
    end
  end
`endif

  assign wbs_dat_o   = dat_q;
  assign checkbits_o = check_q;
  assign io_oeb_o    = oeb_q;

endmodule

// File: tb/tb_randsack_regrw.sv
// Scoreboard bench for randsack_regrw: directed Wishbone transfers, ack-cycle monitor.
module tb_randsack_regrw;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] ID   = 32'h5241_4E44;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [15:0] checkbits_o, io_oeb_o;

  typedef struct {
    logic        is_rd;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [31:0] wcount_exp = '0;

  randsack_regrw #(.BASE_ADDR(BASE), .ID_VALUE(ID)) dut (
    .clock       (clock),
    .resetb      (resetb),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .checkbits_o (checkbits_o),
    .io_oeb_o    (io_oeb_o)
  );

  always #5 clock = ~clock;

  // Monitor: every ack consumes one expected entry; data is zero outside ack cycles.
  always @(negedge clock) begin
    if (wbs_ack_o) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: ack seen with no pending transfer (dat=%h)", wbs_dat_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_rd) begin
          checks++;
          if (wbs_dat_o !== e.data) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, wbs_dat_o, e.data);
          end
        end
      end
    end else begin
      checks++;
      if (wbs_dat_o !== 32'h0) begin
        errors++;
        $display("FAIL dat_idle_zero: got %h expected 00000000", wbs_dat_o);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic is_rd, input logic [31:0] data, input string name);
    exp_t e;
    e.is_rd = is_rd;
    e.data  = data;
    e.name  = name;
    exp_q.push_back(e);
  endtask

  // Classic Wishbone master: hold the request through the ack cycle, drop after it.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic exp_ack, input logic [31:0] exp_rd,
                      input string name);
    logic got;
    got = 1'b0;
    if (exp_ack) push_exp(!we, exp_rd, name);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clock); #1;
      if (wbs_ack_o) got = 1'b1;
    end
    if (got) begin
      @(posedge clock); #1;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    chk({name, "_ack"}, {31'b0, got}, {31'b0, exp_ack});
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] dat, input logic [3:0] sel, input string name);
    xfer(1'b1, BASE + {24'h0, off}, dat, sel, 1'b1, 32'h0, name);
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string name);
    xfer(1'b0, BASE + {24'h0, off}, 32'h0, 4'hF, 1'b1, exp, name);
  endtask

  initial begin
    logic [31:0] scr_exp;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_checkbits", {16'h0, checkbits_o}, 32'h0000_0000);
    chk("rst_oeb_pads",  {16'h0, io_oeb_o},    32'h0000_FFFF);
    chk("rst_ack",       {31'b0, wbs_ack_o},   32'h0);
    @(negedge clock); resetb = 1'b1;
    @(posedge clock); #1;

    rd(8'h00, 32'h5241_4E44, "rd_id");
    rd(8'h04, 32'h0000_0000, "rd_check_rst");
    rd(8'h08, 32'h0000_FFFF, "rd_oeb_rst");
    chk("oeb_pads_after_rst", {16'h0, io_oeb_o}, 32'h0000_FFFF);
    rd(8'h0C, 32'h0, "rd_wcount_rst");

    wr(8'h08, 32'h0, 4'hF, "wr_oeb0");
    chk("oeb_pads_out", {16'h0, io_oeb_o}, 32'h0);
    wr(8'h04, 32'h0000_5555, 4'hF, "wr_check_5555");
    chk("pads_5555", {16'h0, checkbits_o}, 32'h0000_5555);
    wr(8'h04, 32'h0000_AAAA, 4'hF, "wr_check_aaaa");
    chk("pads_aaaa", {16'h0, checkbits_o}, 32'h0000_AAAA);
    wr(8'h04, 32'h0000_FEED, 4'hF, "wr_check_feed");
    chk("pads_feed", {16'h0, checkbits_o}, 32'h0000_FEED);
    wcount_exp = 32'd3;
    rd(8'h0C, wcount_exp, "rd_wcount_3");

    // Byte lanes on CHECK, a sel=0 write that still counts, and upper bits reading 0.
    wr(8'h04, 32'hFFFF_FF00, 4'b0001, "wr_check_lane0");
    chk("pads_lane0", {16'h0, checkbits_o}, 32'h0000_FE00);
    wr(8'h04, 32'h0000_0000, 4'b0000, "wr_check_sel0");
    chk("pads_sel0", {16'h0, checkbits_o}, 32'h0000_FE00);
    wr(8'h04, 32'hABCD_1111, 4'hF, "wr_check_upper");
    rd(8'h04, 32'h0000_1111, "rd_check_upper0");
    wcount_exp = 32'd6;
    rd(8'h0C, wcount_exp, "rd_wcount_6");

`ifdef RANDSACK_SCRATCH_EN
    scr_exp = 32'hFF34_FF78;
`else
    scr_exp = 32'h0;
`endif
    wr(8'h10, 32'hFFFF_FFFF, 4'hF, "wr_scr0_ones");
    wr(8'h10, 32'h1234_5678, 4'b0101, "wr_scr0_lanes");
    rd(8'h10, scr_exp, "rd_scr0");
    rd(8'h1C, 32'h0, "rd_scr3");

    wr(8'h00, 32'hDEAD_BEEF, 4'hF, "wr_id_ro");
    rd(8'h00, 32'h5241_4E44, "rd_id_kept");
    wr(8'h0C, 32'h0, 4'hF, "wr_wcount_ro");
    rd(8'h0C, wcount_exp, "rd_wcount_kept");

    xfer(1'b1, BASE + 32'h100, 32'h1, 4'hF, 1'b0, 32'h0, "wr_out_of_window");
    wbs_stb_i = 1'b1; wbs_adr_i = BASE + 32'h4;
    repeat (3) @(posedge clock);
    #1;
    chk("stb_without_cyc", {31'b0, wbs_ack_o}, 32'h0);
    wbs_stb_i = 1'b0;
    wr(8'h40, 32'hCAFE_F00D, 4'hF, "wr_unmapped40");
    rd(8'h40, 32'h0, "rd_unmapped40");
    rd(8'hFC, 32'h0, "rd_unmappedfc");

    // Strobe held for 8 edges: acks alternate, four writes land.
    for (int i = 0; i < 4; i++) push_exp(1'b0, 32'h0, "burst_wr");
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = BASE + 32'h4; wbs_dat_i = 32'h0000_0F0F; wbs_sel_i = 4'hF;
    for (int i = 0; i < 8; i++) begin
      logic exp_a;
      exp_a = ((i % 2) == 0);
      @(posedge clock); #1;
      chk("burst_ack_pattern", {31'b0, wbs_ack_o}, {31'b0, exp_a});
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wcount_exp = wcount_exp + 32'd4;
    rd(8'h0C, wcount_exp, "rd_wcount_burst");
    chk("pads_burst", {16'h0, checkbits_o}, 32'h0000_0F0F);

    // Reset asserted inside the request cycle, request held through release.
    @(posedge clock); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = BASE + 32'h4; wbs_dat_i = 32'h0000_BEEF; wbs_sel_i = 4'hF;
    #2 resetb = 1'b0;
    #1;
    chk("async_clr_check", {16'h0, checkbits_o}, 32'h0);
    chk("async_oeb_set", {16'h0, io_oeb_o}, 32'h0000_FFFF);
    repeat (2) @(posedge clock);
    #1;
    chk("no_ack_in_reset", {31'b0, wbs_ack_o}, 32'h0);
    push_exp(1'b0, 32'h0, "held_wr");
    @(negedge clock); resetb = 1'b1;
    @(posedge clock); #1;
    chk("ack_after_release", {31'b0, wbs_ack_o}, 32'h1);
    @(posedge clock); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    chk("pads_held_wr", {16'h0, checkbits_o}, 32'h0000_BEEF);
    wcount_exp = 32'd1;
    rd(8'h0C, wcount_exp, "rd_wcount_post_rst");

    repeat (3) @(posedge clock);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
